bitserial_alu_driver: RTL and testbench

Bit-serial command initiator that drives the team's 1-bit logic ALU (a, b, 2-bit Op -> out). Accepts a WIDTH-bit operand pair plus opcode over a valid/ready handshake, feeds one bit pair per cycle to the external 1-bit ALU, and reassembles the returned bits into a WIDTH-bit result. The result is then offered on a second valid/ready handshake. This is the controlling end of the 1-bit ALU interface; the ALU itself stays combinational and outside this block.

---
 rtl/bitserial_alu_driver.sv | 171 +++++++++++++++++
 tb/tb_bitserial_alu_driver.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bitserial_alu_driver.sv
`default_nettype none
// ============================================================================
// Module   : bitserial_alu_driver
// Brief    : Bit-serial command initiator for an external combinational 1-bit
//            logic ALU. Takes a WIDTH-bit operand pair plus opcode, streams
//            one bit pair per cycle (LSB first) to the ALU, reassembles the
//            returned bits and offers the WIDTH-bit result on an output
//            valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module bitserial_alu_driver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  // command side
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_a_i,
  input  logic [WIDTH-1:0] in_b_i,
  input  logic [1:0]       in_op_i,
  // 1-bit ALU side
  output logic             alu_a_o,
  output logic             alu_b_o,
  output logic [1:0]       alu_op_o,
  input  logic             alu_out_i,
  // result side
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_result_o,
  output logic             out_zero_o
);

  // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [1:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             zero_q, zero_d;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_res_shift;

  assign w_accept    = (state_q == S_IDLE) && in_valid_i;
  assign w_last      = (cnt_q == C_LAST);
  // Returned ALU bit enters at the MSB; after WIDTH shifts bit i lines up
  // with operand bit i because operands were sent LSB first.
  assign w_res_shift = {alu_out_i, res_q[WIDTH-1:1]};

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after the last bit,
  // DONE -> IDLE once the result is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode: handshakes and ALU drive depend only on the current state.
  always_comb begin
    in_ready_o   = 1'b0;
    out_valid_o  = 1'b0;
    alu_a_o      = 1'b0;
    alu_b_o      = 1'b0;
    alu_op_o     = op_q;
    out_result_o = res_q;
    out_zero_o   = zero_q;
    case (state_q)
      S_IDLE: begin
        in_ready_o = 1'b1;
      end
      S_RUN: begin
        alu_a_o = a_sh_q[0];
        alu_b_o = b_sh_q[0];
      end
      S_DONE: begin
        out_valid_o = 1'b1;
      end
      default: begin
        in_ready_o = 1'b0;
      end
    endcase
  end

  // Datapath next-state: capture on accept, shift and collect while running.
  always_comb begin
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    res_d  = res_q;
    op_d   = op_q;
    cnt_d  = cnt_q;
    zero_d = zero_q;
    if (w_accept) begin
      a_sh_d = in_a_i;
      b_sh_d = in_b_i;
      op_d   = in_op_i;
      cnt_d  = '0;
      res_d  = '0;
      zero_d = 1'b0;
    end else if (state_q == S_RUN) begin
      a_sh_d = a_sh_q >> 1;
      b_sh_d = b_sh_q >> 1;
      res_d  = w_res_shift;
      // Hold at the last count instead of wrapping.
      if (!w_last) begin
        cnt_d = cnt_q + 1'b1;
      end
      // Zero flag is registered from the final result on DONE entry.
      if (w_last) begin
        zero_d = (w_res_shift == '0);
      end
    end
  end

  // Datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      res_q  <= '0;
      op_q   <= 2'b00;
      cnt_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      res_q  <= res_d;
      op_q   <= op_d;
      cnt_q  <= cnt_d;
      zero_q <= zero_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bitserial_alu_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_bitserial_alu_driver
// Brief    : Directed, table-driven bench for bitserial_alu_driver with a
//            behavioural 1-bit ALU attached to the serial port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bitserial_alu_driver;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic [1:0]   in_op;
  logic         alu_a, alu_b, alu_out;
  logic [1:0]   alu_op;
  logic         out_valid, out_ready;
  logic [W-1:0] out_result;
  logic         out_zero;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // External combinational 1-bit ALU.
  always_comb begin
    case (alu_op)
      2'b00:   alu_out = alu_a & alu_b;
      2'b01:   alu_out = alu_a | alu_b;
      2'b10:   alu_out = ~(alu_a & alu_b);
      default: alu_out = ~(alu_a | alu_b);
    endcase
  end

  bitserial_alu_driver #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_a_i       (in_a),
    .in_b_i       (in_b),
    .in_op_i      (in_op),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_op_o     (alu_op),
    .alu_out_i    (alu_out),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_result_o (out_result),
    .out_zero_o   (out_zero)
  );

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command from IDLE and wait (bounded) for out_valid.
  task automatic run_cmd(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                         output logic [W-1:0] res, output logic z, output int lat,
                         output logic [W-1:0] aseq, output logic ok);
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0; aseq = '0; ok = 1'b0;
    while (lat < 40 && !ok) begin
      if (out_valid) begin
        ok = 1'b1;
      end else begin
        if (lat < W) aseq[lat] = alu_a;
        tick();
        lat++;
      end
    end
    res = out_result;
    z   = out_zero;
  endtask

  task automatic finish_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_in_ready", {31'd0, in_ready}, 32'd1);
    chk("hs_out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] res, aseq;
    logic         z, ok;
    int           lat;
    int           bad;
    int           acc_cyc [2];
    logic [W-1:0] b2b_res [2];
    int           n_acc, n_res;

    vecs[0] = '{2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0};
    vecs[1] = '{2'b01, 8'hA5, 8'h0F, 8'hAF, 1'b0};
    vecs[2] = '{2'b10, 8'hFF, 8'h0F, 8'hF0, 1'b0};
    vecs[3] = '{2'b11, 8'h00, 8'h00, 8'hFF, 1'b0};
    vecs[4] = '{2'b00, 8'h55, 8'hAA, 8'h00, 1'b1};
    vecs[5] = '{2'b01, 8'h00, 8'h00, 8'h00, 1'b1};
    vecs[6] = '{2'b10, 8'hA5, 8'h5A, 8'hFF, 1'b0};
    vecs[7] = '{2'b11, 8'hF0, 8'h0F, 8'h00, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 2'b00; out_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", {24'd0, out_result}, 32'd0);
    chk("rst_out_zero", {31'd0, out_zero}, 32'd0);
    chk("rst_alu_ab", {30'd0, alu_a, alu_b}, 32'd0);
    chk("rst_alu_op", {30'd0, alu_op}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven functional vectors.
    for (int i = 0; i < 8; i++) begin
      chk("vec_idle_ready", {31'd0, in_ready}, 32'd1);
      run_cmd(vecs[i].a, vecs[i].b, vecs[i].op, res, z, lat, aseq, ok);
      chk("vec_timeout", {31'd0, ok}, 32'd1);
      chk("vec_result", {24'd0, res}, {24'd0, vecs[i].res});
      chk("vec_zero", {31'd0, z}, {31'd0, vecs[i].z});
      chk("vec_latency", lat, W);
      chk("vec_alu_a_seq", {24'd0, aseq}, {24'd0, vecs[i].a});
      chk("vec_done_in_ready", {31'd0, in_ready}, 32'd0);
      chk("vec_done_alu", {29'd0, alu_a, alu_op}, {29'd0, 1'b0, vecs[i].op});
      finish_out();
    end

    // Backpressure: result held, new command ignored until handshake.
    run_cmd(8'h3C, 8'h0F, 2'b00, res, z, lat, aseq, ok);
    chk("bp_timeout", {31'd0, ok}, 32'd1);
    in_a = 8'hFF; in_b = 8'h00; in_op = 2'b01; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_result_hold", {24'd0, out_result}, 32'h0C);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("bp_new_accepted", {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("bp_new_latency", lat, W);
    chk("bp_new_result", {24'd0, out_result}, 32'hFF);
    finish_out();

    // Reset at the 4th RUN edge aborts the command.
    in_a = 8'hF0; in_b = 8'hFF; in_op = 2'b01; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_result", {24'd0, out_result}, 32'd0);
    chk("mid_rst_zero", {31'd0, out_zero}, 32'd0);
    chk("mid_rst_alu", {28'd0, alu_a, alu_b, alu_op}, 32'd0);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid || !in_ready) bad++;
    end
    chk("mid_rst_no_valid", bad, 0);
    run_cmd(8'h0F, 8'hFF, 2'b00, res, z, lat, aseq, ok);
    chk("post_rst_timeout", {31'd0, ok}, 32'd1);
    chk("post_rst_result", {24'd0, res}, 32'h0F);
    chk("post_rst_zero", {31'd0, z}, 32'd0);
    finish_out();

    // Back-to-back with in_valid and out_ready held high.
    n_acc = 0; n_res = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    b2b_res[0] = '0; b2b_res[1] = '0;
    in_a = 8'h12; in_b = 8'h40; in_op = 2'b01; in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 60 && n_res < 2; k++) begin
      if (in_ready && in_valid && n_acc < 2) begin
        acc_cyc[n_acc] = k;
        n_acc++;
      end
      if (out_valid && n_res < 2) begin
        b2b_res[n_res] = out_result;
        n_res++;
      end
      tick();
      if (n_acc == 1) begin
        in_a = 8'hCC; in_b = 8'hAA; in_op = 2'b10;
      end else if (n_acc == 2) begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_accepts", n_acc, 2);
    chk("b2b_results", n_res, 2);
    chk("b2b_period", acc_cyc[1] - acc_cyc[0], W + 2);
    chk("b2b_result0", {24'd0, b2b_res[0]}, 32'h52);
    chk("b2b_result1", {24'd0, b2b_res[1]}, 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
